pipeline_run_ctrl: RTL and testbench

PIPELINE_RUN_CTRL -- requirements
Module: pipeline_run_ctrl

---
 rtl/pipeline_run_ctrl_if.sv | 32 +++
 rtl/pipeline_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_run_ctrl_if.sv
// Debug/run-control bundle between the pipeline debug front end and
// the run controller: switch/button levels, PC monitor, breakpoint
// configuration and the resulting enable/status signals.
interface pipeline_run_ctrl_if #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 4,
  parameter int STEP_W = 8
);
  logic                     change;
  logic                     step;
  logic [STEP_W-1:0]        step_count;
  logic [PC_W-1:0]          pc;
  logic [NUM_BP*PC_W-1:0]   bp_addr;
  logic [NUM_BP-1:0]        bp_en;
  logic                     cpu_en;
  logic                     mode;
  logic                     halted;
  logic [NUM_BP-1:0]        bp_hit;
  logic [31:0]              cycle_count;

  // Debug front end / pipeline side
  modport master (
    output change, step, step_count, pc, bp_addr, bp_en,
    input  cpu_en, mode, halted, bp_hit, cycle_count
  );

  // Run controller side
  modport slave (
    input  change, step, step_count, pc, bp_addr, bp_en,
    output cpu_en, mode, halted, bp_hit, cycle_count
  );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Pipeline run controller: run/halt/step FSM driven by a mode switch and a
// step button, with per-channel PC breakpoints. A breakpointed instruction
// never advances; on resume it is let through exactly once via a skip flag.
module pipeline_run_ctrl #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 4,
  parameter int STEP_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_run_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_mode;
  logic                r_skip;
  logic                r_live;
  logic [STEP_W-1:0]   r_count;
  logic [NUM_BP-1:0]   r_bpHit;
  logic [31:0]         r_cycleCount;
  logic [1:0]          r_chgSync;
  logic [1:0]          r_stpSync;
  logic                r_chgDly;
  logic                r_stpDly;

  logic [NUM_BP-1:0]   w_matchVec;
  logic                w_match;
  logic                w_qMatch;
  logic                w_cpuEn;
  logic                w_chgEdge;
  logic                w_stpEdge;
  logic [STEP_W-1:0]   w_loadCount;

  // Per-channel address compare, gated by the channel enable
  for (genvar g = 0; g < NUM_BP; g++) begin : g_bp
    assign w_matchVec[g] = bus.bp_en[g] && (bus.pc == bus.bp_addr[g*PC_W +: PC_W]);
  end

  assign w_match     = |w_matchVec;
  assign w_qMatch    = w_match && !r_skip;
  assign w_cpuEn     = r_live && (r_state != ST_HALT) && !w_qMatch;
  assign w_chgEdge   = r_chgSync[1] && !r_chgDly;
  assign w_stpEdge   = r_stpSync[1] && !r_stpDly;
  assign w_loadCount = (bus.step_count == '0) ? STEP_W'(1) : bus.step_count;

  assign bus.cpu_en      = w_cpuEn;
  assign bus.mode        = r_mode;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.bp_hit      = r_bpHit;
  assign bus.cycle_count = r_cycleCount;

  // Two-flop synchronisers plus a delay flop for rising-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_chgSync <= 2'b00;
      r_stpSync <= 2'b00;
      r_chgDly  <= 1'b0;
      r_stpDly  <= 1'b0;
    end else begin
      r_chgSync <= {r_chgSync[0], bus.change};
      r_stpSync <= {r_stpSync[0], bus.step};
      r_chgDly  <= r_chgSync[1];
      r_stpDly  <= r_stpSync[1];
    end
  end

  // Enable decode is held off until the first edge after reset release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // Free-running count of advanced cycles, wrapping naturally at 2^32
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_cycleCount <= 32'd0;
    else if (w_cpuEn) r_cycleCount <= r_cycleCount + 32'd1;
  end

  // Run-control FSM; a breakpoint beats both mode changes and burst end,
  // and a change edge beats a coincident step edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_mode  <= 1'b0;
      r_skip  <= 1'b0;
      r_count <= '0;
      r_bpHit <= '0;
    end else begin
      if (w_cpuEn) r_skip <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_qMatch) begin
            r_state <= ST_HALT;
            r_bpHit <= w_matchVec;
            r_count <= '0;
          end else if (w_chgEdge) begin
            r_state <= ST_HALT;
            r_mode  <= 1'b1;
          end
        end
        ST_STEP: begin
          if (w_qMatch) begin
            r_state <= ST_HALT;
            r_bpHit <= w_matchVec;
            r_count <= '0;
          end else if (w_chgEdge) begin
            r_state <= ST_RUN;
            r_mode  <= 1'b0;
            r_count <= '0;
          end else if (w_cpuEn) begin
            if (r_count == STEP_W'(1)) begin
              r_state <= ST_HALT;
              r_count <= '0;
            end else begin
              r_count <= r_count - STEP_W'(1);
            end
          end
        end
        ST_HALT: begin
          if (w_chgEdge) begin
            if (!r_mode) begin
              r_mode <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_mode  <= 1'b0;
              r_skip  <= 1'b1;
              r_bpHit <= '0;
            end
          end else if (w_stpEdge) begin
            r_skip  <= 1'b1;
            r_bpHit <= '0;
            if (!r_mode) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_STEP;
              r_count <= w_loadCount;
            end
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for the pipeline run controller: reset, run counting,
// step bursts, breakpoint halt and resume, simultaneous edges, reset abort.
module tb_pipeline_run_ctrl;

  logic clock;
  logic reset;
  int   nVectors;
  int   nMiscompares;

  pipeline_run_ctrl_if #(.PC_W(32), .NUM_BP(4), .STEP_W(8)) bus ();

  pipeline_run_ctrl #(.PC_W(32), .NUM_BP(4), .STEP_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive the debug inputs together at a negedge
  task automatic applyStimulus(input logic chg, input logic stp, input logic [7:0] sc,
                               input logic [31:0] pcVal);
    bus.change     = chg;
    bus.step       = stp;
    bus.step_count = sc;
    bus.pc         = pcVal;
  endtask

  // One comparison of an observed DUT value against a bench-computed value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, ending on the following falling edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    reset        = 1'b0;
    bus.bp_en    = 4'b0000;
    bus.bp_addr  = {32'h0000_0070, 32'h0000_0060, 32'h0000_0040, 32'h0000_0050};
    applyStimulus(1'b0, 1'b0, 8'd0, 32'h100);

    // Reset state
    tick(2);
    checkOutput("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
    checkOutput("rst_halted", 32'(bus.halted), 32'd0);
    checkOutput("rst_mode", 32'(bus.mode), 32'd0);
    checkOutput("rst_bp_hit", 32'(bus.bp_hit), 32'd0);
    checkOutput("rst_cycles", bus.cycle_count, 32'd0);

    // Release: first edge arms decode, then 20 counted cycles
    reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick(1);
      checkOutput("run_cpu_en", 32'(bus.cpu_en), 32'd1);
    end
    checkOutput("run_cycles20", bus.cycle_count, 32'd20);
    checkOutput("run_mode", 32'(bus.mode), 32'd0);

    // Change rise acts on the third edge after it is driven
    applyStimulus(1'b1, 1'b0, 8'd0, 32'h100);
    tick(2);
    checkOutput("chg_not_yet", 32'(bus.halted), 32'd0);
    tick(1);
    checkOutput("chg_halted", 32'(bus.halted), 32'd1);
    checkOutput("chg_mode1", 32'(bus.mode), 32'd1);
    checkOutput("chg_cycles", bus.cycle_count, 32'd23);
    applyStimulus(1'b0, 1'b0, 8'd0, 32'h100);
    tick(3);

    // Step burst of 3
    applyStimulus(1'b0, 1'b1, 8'd3, 32'h100);
    tick(3);
    applyStimulus(1'b0, 1'b0, 8'd3, 32'h100);
    checkOutput("step3_c1", 32'(bus.cpu_en), 32'd1);
    tick(1);
    checkOutput("step3_c2", 32'(bus.cpu_en), 32'd1);
    tick(1);
    checkOutput("step3_c3", 32'(bus.cpu_en), 32'd1);
    tick(1);
    checkOutput("step3_halt", 32'(bus.halted), 32'd1);
    checkOutput("step3_off", 32'(bus.cpu_en), 32'd0);
    checkOutput("step3_cycles", bus.cycle_count, 32'd26);
    tick(2);

    // Change in HALT with mode=1 returns to RUN
    applyStimulus(1'b1, 1'b0, 8'd0, 32'h3C);
    tick(3);
    checkOutput("resume_run", 32'(bus.halted), 32'd0);
    checkOutput("resume_mode0", 32'(bus.mode), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'd0, 32'h3C);
    tick(3);

    // Breakpoint on channel 1 at 0x40
    bus.bp_en = 4'b0010;
    #1;
    checkOutput("bp_pre_en", 32'(bus.cpu_en), 32'd1);
    tick(1);
    bus.pc = 32'h40;
    #1;
    checkOutput("bp_match_off", 32'(bus.cpu_en), 32'd0);
    tick(1);
    checkOutput("bp_halted", 32'(bus.halted), 32'd1);
    checkOutput("bp_hit", 32'(bus.bp_hit), 32'h2);
    checkOutput("bp_mode0", 32'(bus.mode), 32'd0);

    // Step in mode 0 resumes; the halted-on PC advances once only
    applyStimulus(1'b0, 1'b1, 8'd0, 32'h40);
    tick(3);
    applyStimulus(1'b0, 1'b0, 8'd0, 32'h40);
    checkOutput("bp_resume_run", 32'(bus.halted), 32'd0);
    checkOutput("bp_hit_clear", 32'(bus.bp_hit), 32'd0);
    checkOutput("bp_skip_en", 32'(bus.cpu_en), 32'd1);
    tick(1);
    checkOutput("bp_skip_once", 32'(bus.cpu_en), 32'd0);
    tick(1);
    checkOutput("bp_rehalt", 32'(bus.halted), 32'd1);
    checkOutput("bp_rehit", 32'(bus.bp_hit), 32'h2);
    bus.bp_en = 4'b0000;
    applyStimulus(1'b0, 1'b0, 8'd0, 32'h44);
    tick(2);

    // Change in HALT with mode=0 only switches to step mode
    applyStimulus(1'b1, 1'b0, 8'd0, 32'h44);
    tick(3);
    applyStimulus(1'b0, 1'b0, 8'd0, 32'h44);
    checkOutput("hmode_halted", 32'(bus.halted), 32'd1);
    checkOutput("hmode_mode1", 32'(bus.mode), 32'd1);
    checkOutput("hmode_bp_kept", 32'(bus.bp_hit), 32'h2);
    tick(3);

    // step_count of 0 behaves as 1
    applyStimulus(1'b0, 1'b1, 8'd0, 32'h44);
    tick(3);
    applyStimulus(1'b0, 1'b0, 8'd0, 32'h44);
    checkOutput("sc0_en", 32'(bus.cpu_en), 32'd1);
    checkOutput("sc0_bp_clear", 32'(bus.bp_hit), 32'd0);
    tick(1);
    checkOutput("sc0_halt", 32'(bus.halted), 32'd1);
    tick(2);

    // Simultaneous change and step in HALT, mode=1: change wins
    applyStimulus(1'b1, 1'b1, 8'd5, 32'h48);
    tick(3);
    applyStimulus(1'b0, 1'b0, 8'd5, 32'h48);
    checkOutput("sim_run", 32'(bus.halted), 32'd0);
    checkOutput("sim_mode0", 32'(bus.mode), 32'd0);
    tick(6);
    checkOutput("sim_still_run", 32'(bus.halted), 32'd0);

    // Enter step mode and start a 9-cycle burst, then reset at counter=5
    applyStimulus(1'b1, 1'b0, 8'd9, 32'h48);
    tick(3);
    applyStimulus(1'b0, 1'b0, 8'd9, 32'h48);
    checkOutput("abort_halt", 32'(bus.halted), 32'd1);
    tick(3);
    applyStimulus(1'b0, 1'b1, 8'd9, 32'h48);
    tick(3);
    applyStimulus(1'b0, 1'b0, 8'd9, 32'h48);
    tick(4);
    checkOutput("abort_mid_en", 32'(bus.cpu_en), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_cpu_en", 32'(bus.cpu_en), 32'd0);
    checkOutput("abort_halted", 32'(bus.halted), 32'd0);
    checkOutput("abort_mode", 32'(bus.mode), 32'd0);
    checkOutput("abort_cycles", bus.cycle_count, 32'd0);
    tick(1);
    reset = 1'b1;
    tick(12);
    checkOutput("post_run", 32'(bus.halted), 32'd0);
    checkOutput("post_en", 32'(bus.cpu_en), 32'd1);
    checkOutput("post_cycles", bus.cycle_count, 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
